// File: rtl/axil_arith_pkg.sv
// Shared constants for the AXI4-Lite arithmetic coprocessor: register map,
// operation modes, bus responses and FSM state encodings.
package axil_arith_pkg;

  localparam logic [3:0] REG_OPA    = 4'h0;
  localparam logic [3:0] REG_OPB    = 4'h1;
  localparam logic [3:0] REG_CTRL   = 4'h2;
  localparam logic [3:0] REG_STATUS = 4'h3;
  localparam logic [3:0] REG_RES_LO = 4'h4;
  localparam logic [3:0] REG_RES_HI = 4'h5;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_MUL  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] arith_state_t;
  localparam arith_state_t ST_IDLE = 2'd0;
  localparam arith_state_t ST_ADD  = 2'd1;
  localparam arith_state_t ST_MUL  = 2'd2;
  localparam arith_state_t ST_DONE = 2'd3;

  // Byte-lane merge on a 64-bit container; callers cast to their bus width.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 8; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_arith_if.sv
// AXI4-Lite bundle for the arithmetic coprocessor (five channels).
interface axil_arith_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arith_seq_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; done pulses
// for one cycle once the full DATA_WIDTH iterations have completed.
import axil_arith_pkg::*;

module axil_arith_seq_mul #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*DATA_WIDTH-1:0] product_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic                  busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_WIDTH:0]   sum;

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = a_i;
      hi_d    = '0;
      lo_d    = b_i;
    end else if (busy_q) begin
      // Partial product and remaining multiplier bits share one shift register.
      {hi_d, lo_d} = {sum, lo_q[DATA_WIDTH-1:1]};
      cnt_d        = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = {hi_q, lo_q};
endmodule

// File: rtl/axil_arith_unit.sv
// AXI4-Lite arithmetic coprocessor: add/sub/sequential multiply with a polled
// STATUS register. Define ARITH_IRQ_EN to add the irq output and CTRL irq_mask.
import axil_arith_pkg::*;

module axil_arith_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int MUL_CYCLES_LOG2 = 5
) (
  input  logic         s2_axi_aclk,
  input  logic         s2_axi_areset,
  axil_arith_if.slave  s2_axi
`ifdef ARITH_IRQ_EN
  ,
  output logic         irq
`endif
);
  localparam int SW = DATA_WIDTH / 8;

  logic                    aw_q, aw_d, awready_q, awready_d;
  logic [3:0]              awoff_q, awoff_d;
  logic                    w_q, w_d, wready_q, wready_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic                    rvalid_q, rvalid_d, arready_q, arready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [1:0]              mode_q, mode_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  arith_state_t            state_q, state_d;
`ifdef ARITH_IRQ_EN
  logic                    mask_q, mask_d, irq_q, irq_d;
`endif

  logic                    commit, go, mul_start, mul_busy, mul_done, busy_any;
  logic [DATA_WIDTH-1:0]   wr_old, wr_val, ctrl_rd;
  logic [DATA_WIDTH:0]     add_sum;
  logic [2*DATA_WIDTH-1:0] mul_product;

  axil_arith_seq_mul #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (MUL_CYCLES_LOG2)
  ) u_mul (
    .clk       (s2_axi_aclk),
    .rst       (s2_axi_areset),
    .start_i   (mul_start),
    .a_i       (opa_q),
    .b_i       (opb_q),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
`ifdef ARITH_IRQ_EN
    ctrl_rd = DATA_WIDTH'({mask_q, mode_q, 1'b0});
    mask_d  = mask_q;
`else
    ctrl_rd = DATA_WIDTH'({mode_q, 1'b0});
`endif
    aw_d = aw_q;  awoff_d = awoff_q;
    w_d  = w_q;   wdata_d = wdata_q;  wstrb_d = wstrb_q;
    bvalid_d = bvalid_q;  bresp_d = bresp_q;
    rvalid_d = rvalid_q;  rdata_d = rdata_q;  rresp_d = rresp_q;
    opa_d = opa_q;  opb_d = opb_q;  mode_d = mode_q;  res_d = res_q;
    busy_d = busy_q;  done_d = done_q;  ovf_d = ovf_q;  state_d = state_q;
    go = 1'b0;
    mul_start = 1'b0;
    busy_any  = busy_q | mul_busy;
    commit    = aw_q && w_q && !bvalid_q;
    add_sum   = (mode_q == MODE_SUB) ? ({1'b0, opa_q} - {1'b0, opb_q})
                                     : ({1'b0, opa_q} + {1'b0, opb_q});

    if (s2_axi.awvalid && awready_q) begin
      aw_d    = 1'b1;
      awoff_d = s2_axi.awaddr[5:2];
    end
    if (s2_axi.wvalid && wready_q) begin
      w_d     = 1'b1;
      wdata_d = s2_axi.wdata;
      wstrb_d = s2_axi.wstrb;
    end

    case (awoff_q)
      REG_OPA:  wr_old = opa_q;
      REG_OPB:  wr_old = opb_q;
      REG_CTRL: wr_old = ctrl_rd;
      default:  wr_old = '0;
    endcase
    wr_val = DATA_WIDTH'(merge_bytes(64'(wr_old), 64'(wdata_q), 8'(wstrb_q)));

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (awoff_q)
        REG_OPA:    if (busy_any) bresp_d = RESP_SLVERR; else opa_d = wr_val;
        REG_OPB:    if (busy_any) bresp_d = RESP_SLVERR; else opb_d = wr_val;
        REG_CTRL: begin
          if (busy_any || (wr_val[0] && wr_val[2:1] == MODE_RSVD)) begin
            bresp_d = RESP_SLVERR;
          end else begin
            mode_d = wr_val[2:1];
            go     = wr_val[0];
`ifdef ARITH_IRQ_EN
            mask_d = wr_val[3];
`endif
          end
        end
        REG_STATUS: if (wstrb_q[0] && wdata_q[1]) done_d = 1'b0;
        default:    bresp_d = RESP_SLVERR;
      endcase
    end
    // Both address and data latches stay occupied until the response is taken.
    if (bvalid_q && s2_axi.bready) begin
      bvalid_d = 1'b0;
      aw_d     = 1'b0;
      w_d      = 1'b0;
    end
    awready_d = !aw_d;
    wready_d  = !w_d;

    case (state_q)
      ST_ADD: begin
        res_d   = {{(DATA_WIDTH-1){1'b0}}, add_sum};
        ovf_d   = add_sum[DATA_WIDTH];
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_MUL: begin
        if (mul_done) begin
          res_d   = mul_product;
          ovf_d   = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (go) begin
      state_d   = (mode_d == MODE_MUL) ? ST_MUL : ST_ADD;
      mul_start = (mode_d == MODE_MUL);
      busy_d    = 1'b1;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
    end

    if (s2_axi.arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (s2_axi.araddr[5:2])
        REG_OPA:    rdata_d = opa_q;
        REG_OPB:    rdata_d = opb_q;
        REG_CTRL:   rdata_d = ctrl_rd;
        REG_STATUS: rdata_d = DATA_WIDTH'({ovf_q, done_q, busy_q});
        REG_RES_LO: rdata_d = res_q[DATA_WIDTH-1:0];
        REG_RES_HI: rdata_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end else if (rvalid_q && s2_axi.rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;

`ifdef ARITH_IRQ_EN
    irq_d = done_d & ~mask_d;
`endif
  end

  always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
    if (s2_axi_areset) begin
      aw_q <= 1'b0;  awready_q <= 1'b0;  awoff_q <= '0;
      w_q  <= 1'b0;  wready_q  <= 1'b0;  wdata_q <= '0;  wstrb_q <= '0;
      bvalid_q <= 1'b0;  bresp_q <= RESP_OKAY;
      rvalid_q <= 1'b0;  arready_q <= 1'b0;  rdata_q <= '0;  rresp_q <= RESP_OKAY;
      opa_q <= '0;  opb_q <= '0;  mode_q <= MODE_ADD;  res_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  ovf_q <= 1'b0;  state_q <= ST_IDLE;
`ifdef ARITH_IRQ_EN
      mask_q <= 1'b0;  irq_q <= 1'b0;
`endif
    end else begin
      aw_q <= aw_d;  awready_q <= awready_d;  awoff_q <= awoff_d;
      w_q  <= w_d;   wready_q  <= wready_d;   wdata_q <= wdata_d;  wstrb_q <= wstrb_d;
      bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;  arready_q <= arready_d;  rdata_q <= rdata_d;  rresp_q <= rresp_d;
      opa_q <= opa_d;  opb_q <= opb_d;  mode_q <= mode_d;  res_q <= res_d;
      busy_q <= busy_d;  done_q <= done_d;  ovf_q <= ovf_d;  state_q <= state_d;
`ifdef ARITH_IRQ_EN
      mask_q <= mask_d;  irq_q <= irq_d;
`endif
    end
  end

  assign s2_axi.awready = awready_q;
  assign s2_axi.wready  = wready_q;
  assign s2_axi.bvalid  = bvalid_q;
  assign s2_axi.bresp   = bresp_q;
  assign s2_axi.arready = arready_q;
  assign s2_axi.rvalid  = rvalid_q;
  assign s2_axi.rdata   = rdata_q;
  assign s2_axi.rresp   = rresp_q;
`ifdef ARITH_IRQ_EN
  assign irq = irq_q;
`endif
endmodule
